// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle logic/arithmetic/compare ops,
// bit-serial shifts (one bit per cycle) and an iterative shift-add multiplier.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sel_alu,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] outp,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = SHW + 1;

    localparam logic [3:0] OpNot = 4'h0, OpAnd = 4'h1, OpXor = 4'h2, OpOr   = 4'h3;
    localparam logic [3:0] OpDec = 4'h4, OpAdd = 4'h5, OpSub = 4'h6, OpInc  = 4'h7;
    localparam logic [3:0] OpSll = 4'h8, OpSrl = 4'h9, OpSra = 4'hA, OpMul  = 4'hB;
    localparam logic [3:0] OpSlt = 4'hC, OpSltu = 4'hD;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, outp_q, outp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;
    logic             ovf_q, ovf_d, ill_q, ill_d;

    logic [SHW-1:0]   shamt;
    logic             is_sub, is_unit, add_v, sh_out;
    logic [WIDTH-1:0] opb, addend, sh_next, mul_acc;
    logic [WIDTH:0]   sum;
    logic             fin, fin_c, fin_v, fin_ill;
    logic [WIDTH-1:0] fin_res;

    // Shared adder: subtraction is A + ~B + 1, so the carry out means "no borrow".
    always_comb begin
        shamt   = inp2[SHW-1:0];
        is_sub  = (sel_alu == OpSub) || (sel_alu == OpDec);
        is_unit = (sel_alu == OpInc) || (sel_alu == OpDec);
        opb     = is_unit ? WIDTH'(1) : inp2;
        addend  = is_sub ? ~opb : opb;
        sum     = {1'b0, inp1} + {1'b0, addend} + {{WIDTH{1'b0}}, is_sub};
        add_v   = (inp1[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != inp1[WIDTH-1]);
    end

    always_comb begin
        if (op_q == OpSll) begin
            sh_next = {a_q[WIDTH-2:0], 1'b0};
            sh_out  = a_q[WIDTH-1];
        end else if (op_q == OpSrl) begin
            sh_next = {1'b0, a_q[WIDTH-1:1]};
            sh_out  = a_q[0];
        end else begin
            sh_next = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
            sh_out  = a_q[0];
        end
        mul_acc = acc_q + (b_q[0] ? a_q : '0);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        outp_d  = outp_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
        fin     = 1'b0;
        fin_res = '0;
        fin_c   = 1'b0;
        fin_v   = 1'b0;
        fin_ill = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d  = sel_alu;
                    a_d   = inp1;
                    b_d   = inp2;
                    acc_d = '0;
                    case (sel_alu)
                        OpNot: begin fin = 1'b1; fin_res = ~inp1;        end
                        OpAnd: begin fin = 1'b1; fin_res = inp1 & inp2;  end
                        OpXor: begin fin = 1'b1; fin_res = inp1 ^ inp2;  end
                        OpOr:  begin fin = 1'b1; fin_res = inp1 | inp2;  end
                        OpDec, OpAdd, OpSub, OpInc: begin
                            fin     = 1'b1;
                            fin_res = sum[WIDTH-1:0];
                            fin_c   = sum[WIDTH];
                            fin_v   = add_v;
                        end
                        OpSll, OpSrl, OpSra: begin
                            if (shamt == '0) begin
                                fin     = 1'b1;
                                fin_res = inp1;
                            end else begin
                                cnt_d   = CW'(shamt);
                                state_d = StBusy;
                            end
                        end
                        OpMul: begin
                            cnt_d   = CW'(WIDTH);
                            state_d = StBusy;
                        end
                        OpSlt: begin
                            fin     = 1'b1;
                            fin_res = {{(WIDTH-1){1'b0}}, $signed(inp1) < $signed(inp2)};
                        end
                        OpSltu: begin
                            fin     = 1'b1;
                            fin_res = {{(WIDTH-1){1'b0}}, inp1 < inp2};
                        end
                        default: begin
                            fin     = 1'b1;
                            fin_ill = 1'b1;
                        end
                    endcase
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OpMul) begin
                    acc_d = mul_acc;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    if (cnt_q == CW'(1)) begin
                        fin     = 1'b1;
                        fin_res = mul_acc;
                    end
                end else begin
                    a_d = sh_next;
                    if (cnt_q == CW'(1)) begin
                        fin     = 1'b1;
                        fin_res = sh_next;
                        fin_c   = sh_out;
                    end
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (fin) begin
            state_d = StDone;
            outp_d  = fin_res;
            zero_d  = (fin_res == '0);
            neg_d   = fin_res[WIDTH-1];
            carry_d = fin_c;
            ovf_d   = fin_v;
            ill_d   = fin_ill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            outp_q  <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            outp_q  <= outp_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign outp      = outp_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): scoreboard of expected results, latency,
// backpressure and reset-abort checks.
module tb_alu_seq;
    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  sel_alu;
    logic [31:0] inp1, inp2, outp;
    logic        zero, negative, carry, overflow, illegal;

    typedef struct {
        logic [31:0] res;
        logic        z, n, c, v, ill;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel_alu(sel_alu), .inp1(inp1), .inp2(inp2), .out_valid(out_valid),
        .out_ready(out_ready), .outp(outp), .zero(zero), .negative(negative),
        .carry(carry), .overflow(overflow), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        logic [32:0] w;
        int          sh;
        sh    = int'(b[4:0]);
        e.res = '0; e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0; e.lat = 1;
        case (op)
            4'h0: e.res = ~a;
            4'h1: e.res = a & b;
            4'h2: e.res = a ^ b;
            4'h3: e.res = a | b;
            4'h4: begin e.res = a - 1; e.c = (a != 0); e.v = (a == 32'h8000_0000); end
            4'h5: begin
                w = {1'b0, a} + {1'b0, b};
                e.res = w[31:0]; e.c = w[32];
                e.v = (a[31] == b[31]) && (e.res[31] != a[31]);
            end
            4'h6: begin
                e.res = a - b; e.c = (a >= b);
                e.v = (a[31] != b[31]) && (e.res[31] != a[31]);
            end
            4'h7: begin e.res = a + 1; e.c = (a == 32'hFFFF_FFFF); e.v = (a == 32'h7FFF_FFFF); end
            4'h8: begin e.res = a << sh; if (sh != 0) e.c = a[32-sh]; e.lat = sh + 1; end
            4'h9: begin e.res = a >> sh; if (sh != 0) e.c = a[sh-1]; e.lat = sh + 1; end
            4'hA: begin
                e.res = 32'($signed(a) >>> sh);
                if (sh != 0) e.c = a[sh-1];
                e.lat = sh + 1;
            end
            4'hB: begin e.res = a * b; e.lat = 33; end
            4'hC: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hD: e.res = (a < b) ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 0);
        e.n = e.res[31];
        return e;
    endfunction

    task automatic check_result(input string pfx, input exp_t e);
        check({pfx, "_outp"}, 64'(outp), 64'(e.res));
        check({pfx, "_zero"}, 64'(zero), 64'(e.z));
        check({pfx, "_negative"}, 64'(negative), 64'(e.n));
        check({pfx, "_carry"}, 64'(carry), 64'(e.c));
        check({pfx, "_overflow"}, 64'(overflow), 64'(e.v));
        check({pfx, "_illegal"}, 64'(illegal), 64'(e.ill));
    endtask

    // Called mid-cycle; returns at posedge+1 with the block back in IDLE.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        exp_t e;
        int   lat;
        in_valid = 1'b1; sel_alu = op; inp1 = a; inp2 = b;
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        sb_q.push_back(model(op, a, b));
        in_valid = 1'b0; inp1 = $urandom; inp2 = $urandom; sel_alu = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb_q.pop_front();
        check("out_valid_seen", 64'(out_valid), 64'd1);
        check("latency", 64'(lat), 64'(e.lat));
        check_result("result", e);
        in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check_result("hold", e);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sel_alu = '0; inp1 = '0; inp2 = '0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outp", 64'(outp), 64'd0);
        check("rst_flags", 64'({zero, negative, carry, overflow, illegal}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'h5, 32'h7FFF_FFFF, 32'd1, 0);
        do_op(4'h6, 32'd5, 32'd5, 0);
        do_op(4'h6, 32'd0, 32'd1, 0);
        do_op(4'hA, 32'h8000_0001, 32'd4, 3);
        do_op(4'h8, 32'hDEAD_BEEF, 32'd0, 0);
        do_op(4'hB, 32'h0001_0000, 32'h0001_0000, 0);
        do_op(4'hB, 32'd7, 32'd6, 1);
        do_op(4'hE, 32'h1234_5678, 32'd9, 0);
        do_op(4'hF, 32'd0, 32'd0, 0);
        do_op(4'hC, 32'hFFFF_FFFF, 32'd1, 0);
        do_op(4'hD, 32'hFFFF_FFFF, 32'd1, 0);
        do_op(4'h4, 32'h8000_0000, 32'd0, 0);
        do_op(4'h7, 32'hFFFF_FFFF, 32'd0, 0);
        do_op(4'h9, 32'h8000_0003, 32'd31, 0);
        do_op(4'h0, 32'h0F0F_0000, 32'd0, 0);
        for (int i = 0; i < 20; i++)
            do_op(4'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(0, 2)));

        // Abort a multiply in its tenth busy cycle.
        in_valid = 1'b1; sel_alu = 4'hB; inp1 = 32'd3; inp2 = 32'd5;
        @(posedge clk); #1;
        sb_q.push_back(model(4'hB, 32'd3, 32'd5));
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_outp", 64'(outp), 64'd0);
        check("abort_flags", 64'({zero, negative, carry, overflow, illegal}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_never_presented", 64'(seen), 64'd0);
        do_op(4'h5, 32'd2, 32'd3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64, power of two).
REQ-002 SHALL have derived parameter SHW = log2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operation request.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-007 SHALL have port sel_alu, input, 4 bits: opcode.
REQ-008 SHALL have ports inp1 and inp2, input, WIDTH bits each: operands A and B.
REQ-009 SHALL have port out_valid, output, 1 bit: result available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port outp, output, WIDTH bits: result.
REQ-012 SHALL have ports zero, negative, carry and overflow, output, 1 bit each: result flags.
REQ-013 SHALL have port illegal, output, 1 bit: the opcode was undefined.

Function
REQ-014 Opcodes SHALL be:
- 0000 NOT A
- 0001 A AND B
- 0010 A XOR B
- 0011 A OR B
- 0100 A-1
- 0101 A+B
- 0110 A-B
- 0111 A+1
- 1000 SLL
- 1001 SRL
- 1010 SRA
- 1011 MUL (low WIDTH bits, unsigned)
- 1100 SLT (signed)
- 1101 SLTU
- 1110 and 1111 illegal
REQ-015 Shift amount SHALL be inp2[SHW-1:0]; shifts SHALL operate on inp1.
REQ-016 State machine SHALL have states IDLE, BUSY and DONE, and reset to IDLE.
REQ-017 in_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where in_valid=1 and in_ready=1.
REQ-018 On accept, operands and opcode SHALL be captured; later input changes SHALL NOT affect the in-flight operation.
REQ-019 Opcodes 0000-0111, 1100, 1101 and illegal opcodes SHALL go IDLE->DONE, so out_valid=1 on the cycle after accept (latency 1).
REQ-020 Shifts SHALL move one bit per cycle in BUSY, latency shamt+1; shamt=0 SHALL go directly to DONE with latency 1 and result inp1.
REQ-021 MUL SHALL be iterative shift-add, one multiplier bit per cycle in BUSY, fixed latency WIDTH+1.
REQ-022 out_valid SHALL be 1 only in DONE; outp and all flags SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 DONE with out_ready=1 SHALL go to IDLE; a new request SHALL NOT be accepted in the same cycle (throughput 1 per latency+1).
REQ-024 zero SHALL be (outp==0); negative SHALL be outp[WIDTH-1], for all opcodes.
REQ-025 carry SHALL be:
- ADD/INC: the carry out of bit WIDTH-1.
- SUB/DEC: 1 when there is no borrow.
- Shifts: the last bit shifted out (0 when shamt=0).
- All other opcodes: 0.
REQ-026 overflow SHALL be two's-complement signed overflow for ADD/SUB/INC/DEC, 0 otherwise.
REQ-027 SLT/SLTU SHALL return 1 or 0, zero-extended to WIDTH bits.
REQ-028 Illegal opcodes SHALL give illegal=1, outp=0 and zero=1, with the other flags 0; illegal SHALL be 0 for legal opcodes.
REQ-029 Arithmetic SHALL wrap modulo 2^WIDTH, with no saturation.

Reset
REQ-030 While rst_n=0, regardless of clk:
- state=IDLE
- in_ready=1 (IDLE)
- out_valid=0
- outp=0
- all flags=0
- internal counters=0
REQ-031 Reset asserted mid-BUSY or in DONE SHALL abort the operation; the result SHALL be discarded and SHALL never be presented.
REQ-032 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=32)
REQ-033 ADD A=0x7FFFFFFF, B=1 -> next cycle out_valid=1, outp=0x80000000, overflow=1, carry=0, negative=1.
REQ-034 SUB A=5, B=5 -> outp=0, zero=1, carry=1, overflow=0; SUB A=0, B=1 -> outp=0xFFFFFFFF, carry=0.
REQ-035 SRA A=0x80000001, B=4 -> out_valid exactly 5 cycles after accept, outp=0xF8000000, carry=0; SLL shamt=0 -> latency 1, outp=A, carry=0.
REQ-036 MUL A=0x00010000, B=0x00010000 -> out_valid 33 cycles after accept, outp=0, zero=1; MUL A=7, B=6 -> outp=42.
REQ-037 Backpressure: hold out_ready=0 for 3 cycles in DONE -> outp and flags unchanged, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-038 Reset pulse in cycle 10 of a MUL -> out_valid=0 immediately; after release in_ready=1; a later ADD 2+3 -> outp=5.
